// File: rtl/muxsplit_bbm_sequencer_if.sv
// Control-side bundle for the muxsplit break-before-make sequencer.
// Carries the requested switch map in and the switch drive and status out.
interface muxsplit_bbm_sequencer_if;
    localparam int unsigned SW_W = 24;

    logic            enable;
    logic            force_open;
    logic [SW_W-1:0] req_cfg;
    logic [SW_W-1:0] sw_out;
    logic            busy;
    logic            done;

    modport master (
        output enable, force_open, req_cfg,
        input  sw_out, busy, done
    );

    modport slave (
        input  enable, force_open, req_cfg,
        output sw_out, busy, done
    );
endinterface

// File: rtl/muxsplit_bbm_sequencer.sv
// Break-before-make sequencer for the 24 muxsplit analog switch controls.
// Switches leaving the map open first; joining switches close after a programmable gap.
module muxsplit_bbm_sequencer #(
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned BREAK_CYCLES  = 4,
    parameter int unsigned SETTLE_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    muxsplit_bbm_sequencer_if.slave   bus
);
    localparam int unsigned SW_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GAP    = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [SW_W-1:0]   target, target_nxt;
    logic [SW_W-1:0]   sw_q, sw_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              busy_q, done_q, done_nxt;
    logic              start_c, need_break_c;

    assign start_c      = bus.enable && !bus.force_open && (bus.req_cfg != sw_q);
    assign need_break_c = (sw_q & ~bus.req_cfg) != '0;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; force_open overrides every state
    always_comb begin
        state_nxt = state;
        if (bus.force_open) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:   if (start_c) state_nxt = need_break_c ? ST_GAP : ST_SETTLE;
                ST_GAP:    if (cnt == '0) state_nxt = ST_SETTLE;
                ST_SETTLE: if (cnt == '0) state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output/datapath next values; sw drive only ever loses bits before the make step
    always_comb begin
        sw_nxt     = sw_q;
        target_nxt = target;
        cnt_nxt    = cnt;
        done_nxt   = 1'b0;
        if (bus.force_open) begin
            sw_nxt  = '0;
            cnt_nxt = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start_c) begin
                        target_nxt = bus.req_cfg;
                        if (need_break_c) begin
                            sw_nxt  = sw_q & bus.req_cfg;
                            cnt_nxt = CNT_W'(BREAK_CYCLES - 1);
                        end else begin
                            sw_nxt  = bus.req_cfg;
                            cnt_nxt = CNT_W'(SETTLE_CYCLES - 1);
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt == '0) begin
                        sw_nxt  = target;
                        cnt_nxt = CNT_W'(SETTLE_CYCLES - 1);
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (cnt == '0) done_nxt = 1'b1;
                    else           cnt_nxt  = cnt - CNT_W'(1);
                end
                default: begin
                    sw_nxt  = '0;
                    cnt_nxt = '0;
                end
            endcase
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_q   <= '0;
            target <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sw_q   <= sw_nxt;
            target <= target_nxt;
            cnt    <= cnt_nxt;
            busy_q <= (state_nxt != ST_IDLE);
            done_q <= done_nxt;
        end
    end

    assign bus.sw_out = sw_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule
